// File: rtl/axis_test_patern_checker_if.sv
// Stream configuration type and the AXI-Stream bundle shared by the test-pattern generator and checker.
package axis_pkg;
  typedef struct packed {
    int N;
  } axis_cfg_t;
endpackage

interface axis_if #(
  parameter int N = 8
) ();
  logic [N*8-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;
  logic           tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_test_patern_checker.sv
// Locks onto the {counter, word index} stream pattern and checks every accepted beat; stats update one cycle after accept.
// tready depends only on state and the throttle LFSR, never on tvalid; throttling gates tready with LFSR bit 0.
module axis_test_patern_checker #(
  parameter axis_pkg::axis_cfg_t CONFIG    = '{N: 0},
  parameter int                  W         = 4,
  parameter int                  WPB       = 2,
  parameter int                  CNT_W     = 32,
  parameter logic [15:0]         LFSR_SEED = 16'hACE1
) (
  input  logic             aclk,
  input  logic             areset,
  axis_if.slave            axis_in,
  input  logic             enable,
  input  logic             throttle_en,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] first_err_beat
);
  localparam int WB   = W * 8;
  localparam int W_LG = $clog2(W);
  localparam int CW   = WB - W_LG;
  localparam int DW   = WB * WPB;

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  if ((CONFIG.N != W * WPB) || (W < 2) || ((W & (W - 1)) != 0) || ((WPB & (WPB - 1)) != 0))
  begin : g_cfg_check
    always_ff @(posedge aclk) begin
      $fatal(1, "axis_test_patern_checker: CONFIG.N must equal W*WPB with W, WPB powers of two");
    end
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    exp_cnt_q, exp_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] error_count_q, error_count_d;
  logic [CNT_W-1:0] beat_count_q, beat_count_d;
  logic [CNT_W-1:0] first_err_beat_q, first_err_beat_d;

  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic          accept;
  logic          lfsr_fb;
  logic [CW-1:0] word0_cnt;
  logic          consistent;
  logic          match;
  logic          unused_sideband;

  assign in_data         = axis_in.tdata;
  assign unused_sideband = axis_in.tlast ^ axis_in.tuser;

  assign in_rdy         = (state_q != IDLE) && (!throttle_en || lfsr_q[0]);
  assign axis_in.tready = in_rdy;
  assign accept         = axis_in.tvalid && in_rdy;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    word0_cnt  = in_data[W_LG +: CW];
    consistent = 1'b1;
    match      = 1'b1;
    for (int j = 0; j < WPB; j++) begin
      if (in_data[j*WB +: W_LG] != W_LG'(j)) consistent = 1'b0;
      if (in_data[j*WB+W_LG +: CW] != word0_cnt) consistent = 1'b0;
      if (in_data[j*WB +: WB] != {exp_cnt_q, W_LG'(j)}) match = 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    exp_cnt_d        = exp_cnt_q;
    lfsr_d           = throttle_en ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    locked_d         = locked_q;
    error_d          = error_q;
    error_count_d    = error_count_q;
    beat_count_d     = beat_count_q;
    first_err_beat_d = first_err_beat_q;

    if (clear) begin
      // a beat accepted alongside clear is dropped unchecked
      state_d          = enable ? HUNT : IDLE;
      locked_d         = 1'b0;
      error_d          = 1'b0;
      error_count_d    = '0;
      beat_count_d     = '0;
      first_err_beat_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = HUNT;
        end
        HUNT: begin
          if (accept) begin
            beat_count_d = sat_inc(beat_count_q);
            if (consistent) begin
              exp_cnt_d = word0_cnt + CW'(1);
              state_d   = LOCKED;
              locked_d  = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            beat_count_d = sat_inc(beat_count_q);
            if (match) begin
              exp_cnt_d = exp_cnt_q + CW'(1);
            end else begin
              error_count_d = sat_inc(error_count_q);
              error_d       = 1'b1;
              if (!error_q) first_err_beat_d = beat_count_q;
              exp_cnt_d = word0_cnt + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (!enable) begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q          <= IDLE;
      exp_cnt_q        <= '0;
      lfsr_q           <= LFSR_SEED;
      locked_q         <= 1'b0;
      error_q          <= 1'b0;
      error_count_q    <= '0;
      beat_count_q     <= '0;
      first_err_beat_q <= '0;
    end else begin
      state_q          <= state_d;
      exp_cnt_q        <= exp_cnt_d;
      lfsr_q           <= lfsr_d;
      locked_q         <= locked_d;
      error_q          <= error_d;
      error_count_q    <= error_count_d;
      beat_count_q     <= beat_count_d;
      first_err_beat_q <= first_err_beat_d;
    end
  end

  assign locked         = locked_q;
  assign error          = error_q;
  assign error_count    = error_count_q;
  assign beat_count     = beat_count_q;
  assign first_err_beat = first_err_beat_q;

endmodule

// File: tb/tb_axis_test_patern_checker.sv
// Directed bench for the stream pattern checker, W=4 WPB=2: a beat with counter c is {c<<2|1, c<<2|0}.
module tb_axis_test_patern_checker;
  localparam int W     = 4;
  localparam int WPB   = 2;
  localparam int N     = 8;
  localparam int CNT_W = 32;
  localparam axis_pkg::axis_cfg_t CFG = '{N: 8};

  logic             aclk = 1'b0;
  logic             areset;
  logic             enable;
  logic             throttle_en;
  logic             clear;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] beat_count;
  logic [CNT_W-1:0] first_err_beat;

  axis_if #(.N(N)) axis_bus ();

  axis_test_patern_checker #(
    .CONFIG   (CFG),
    .W        (W),
    .WPB      (WPB),
    .CNT_W    (CNT_W),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .axis_in       (axis_bus),
    .enable        (enable),
    .throttle_en   (throttle_en),
    .clear         (clear),
    .locked        (locked),
    .error         (error),
    .error_count   (error_count),
    .beat_count    (beat_count),
    .first_err_beat(first_err_beat)
  );

  always #5 aclk = ~aclk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int rdy_hi   = 0;
  int rdy_lo   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [29:0] c);
    return {c, 2'b01, c, 2'b00};
  endfunction

  // Generator side: hold the beat stable until tready is seen, bounded wait.
  task automatic send_raw(input logic [63:0] d);
    logic acc = 1'b0;
    axis_bus.tdata  = d;
    axis_bus.tvalid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge aclk);
      acc = axis_bus.tready;
      if (acc) rdy_hi++;
      else     rdy_lo++;
      @(posedge aclk);
      #1;
    end
    axis_bus.tvalid = 1'b0;
    chk("accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_seq(input logic [29:0] first, input int count);
    logic [29:0] c = first;
    repeat (count) begin
      send_raw(mk(c));
      c++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge aclk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    areset          = 1'b1;
    enable          = 1'b0;
    throttle_en     = 1'b0;
    clear           = 1'b0;
    axis_bus.tdata  = '0;
    axis_bus.tvalid = 1'b0;
    axis_bus.tlast  = 1'b0;
    axis_bus.tuser  = 1'b0;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", {63'd0, axis_bus.tready}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_beats", 64'(beat_count), 64'd0);
    chk("rst_errs", 64'(error_count), 64'd0);
    chk("rst_first", 64'(first_err_beat), 64'd0);

    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("idle_tready", {63'd0, axis_bus.tready}, 64'd0);

    // basic run
    enable = 1'b1;
    @(posedge aclk);
    #1;
    chk("hunt_unlocked", {63'd0, locked}, 64'd0);
    rdy_hi = 0;
    rdy_lo = 0;
    send_raw(mk(30'd0));
    chk("basic_lock_first", {63'd0, locked}, 64'd1);
    send_seq(30'd1, 99);
    chk("basic_stalls", 64'(rdy_lo), 64'd0);
    chk("basic_beats", 64'(beat_count), 64'd100);
    chk("basic_errs", 64'(error_count), 64'd0);
    chk("basic_error", {63'd0, error}, 64'd0);

    // dropped beat
    do_clear();
    chk("clr_beats", 64'(beat_count), 64'd0);
    chk("clr_locked", {63'd0, locked}, 64'd0);
    send_seq(30'd0, 10);
    send_seq(30'd11, 10);
    chk("drop_errs", 64'(error_count), 64'd1);
    chk("drop_first", 64'(first_err_beat), 64'd10);
    chk("drop_locked", {63'd0, locked}, 64'd1);
    chk("drop_error", {63'd0, error}, 64'd1);
    chk("drop_beats", 64'(beat_count), 64'd20);

    // corrupted index in word 1 at c=3
    do_clear();
    chk("clr_error", {63'd0, error}, 64'd0);
    send_seq(30'd0, 3);
    send_raw({32'h0000000E, 32'h0000000C});
    chk("cidx_errs_now", 64'(error_count), 64'd1);
    send_seq(30'd4, 4);
    chk("cidx_errs", 64'(error_count), 64'd1);
    chk("cidx_first", 64'(first_err_beat), 64'd3);
    chk("cidx_beats", 64'(beat_count), 64'd8);

    // inconsistent beats while hunting are counted but never flagged
    do_clear();
    send_raw({32'h0000001D, 32'h00000014});
    send_raw({32'h00000015, 32'h00000015});
    chk("hunt_bad_locked", {63'd0, locked}, 64'd0);
    chk("hunt_bad_errs", 64'(error_count), 64'd0);
    chk("hunt_bad_beats", 64'(beat_count), 64'd2);
    send_seq(30'd9, 2);
    chk("hunt_ok_locked", {63'd0, locked}, 64'd1);
    chk("hunt_ok_errs", 64'(error_count), 64'd0);

    // counter wrap
    do_clear();
    send_seq(30'h3FFFFFFE, 4);
    chk("wrap_errs", 64'(error_count), 64'd0);
    chk("wrap_locked", {63'd0, locked}, 64'd1);
    chk("wrap_beats", 64'(beat_count), 64'd4);

    // throttled tready
    do_clear();
    throttle_en = 1'b1;
    rdy_hi = 0;
    rdy_lo = 0;
    send_seq(30'd100, 200);
    throttle_en = 1'b0;
    chk("thr_saw_low", {63'd0, rdy_lo != 0}, 64'd1);
    chk("thr_saw_high", {63'd0, rdy_hi != 0}, 64'd1);
    chk("thr_beats", 64'(beat_count), 64'd200);
    chk("thr_errs", 64'(error_count), 64'd0);

    // clear coincident with an accepted beat
    axis_bus.tdata  = mk(30'd300);
    axis_bus.tvalid = 1'b1;
    clear           = 1'b1;
    @(negedge aclk);
    chk("clracc_tready", {63'd0, axis_bus.tready}, 64'd1);
    @(posedge aclk);
    #1;
    clear           = 1'b0;
    axis_bus.tvalid = 1'b0;
    chk("clracc_beats", 64'(beat_count), 64'd0);
    chk("clracc_locked", {63'd0, locked}, 64'd0);
    chk("clracc_errs", 64'(error_count), 64'd0);
    send_seq(30'd301, 1);
    chk("clracc_relock", {63'd0, locked}, 64'd1);
    chk("clracc_beats1", 64'(beat_count), 64'd1);

    // asynchronous reset mid-stream
    send_seq(30'd302, 5);
    areset = 1'b1;
    #1;
    chk("arst_tready", {63'd0, axis_bus.tready}, 64'd0);
    chk("arst_beats", 64'(beat_count), 64'd0);
    chk("arst_locked", {63'd0, locked}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    send_seq(30'd500, 10);
    chk("arst_relock", {63'd0, locked}, 64'd1);
    chk("arst_errs", 64'(error_count), 64'd0);
    chk("arst_beats10", 64'(beat_count), 64'd10);

    // disable returns to idle and holds statistics
    enable = 1'b0;
    @(posedge aclk);
    #1;
    chk("dis_locked", {63'd0, locked}, 64'd0);
    chk("dis_tready", {63'd0, axis_bus.tready}, 64'd0);
    chk("dis_beats", 64'(beat_count), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
